bp_resolve_queue: RTL
=====================

Name: bp_resolve_queue

Overview:
- Producer end of the predictor training interface: the execute-side block that resolves branches and emits update packets to the branch predictor.
- Compares each resolved branch's actual outcome and target against the prediction carried down the pipeline.
- Raises a registered mispredict/redirect pulse on a mismatch.
- Buffers resolved branches in a FIFO and drains one predictor update per cycle under a stall handshake.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- XLEN, `XLEN, address width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  squash all queued entries and any pending redirect.
- ex_valid  in  1  a resolved instruction is presented.
- ex_ready  out  1  queue can accept; equals (count < DEPTH).
- ex_pc  in  XLEN  PC of the resolved instruction.
- ex_cond  in  1  instruction is a conditional branch.
- ex_uncond  in  1  instruction is a jal or jalr.
- ex_taken  in  1  actual direction; ignored when ex_uncond=1 (treated as 1).
- ex_tg_pc  in  XLEN  actual target.
- ex_pred_taken  in  1  direction predicted at fetch.
- ex_pred_pc  in  XLEN  next PC predicted at fetch.
- upd_valid  out  1  head update is valid.
- upd_stall  in  1  predictor cannot take an update this cycle.
- upd_cond  out  1  head is conditional; this is the BHT/PHT write enable.
- upd_pc  out  XLEN  head branch PC.
- upd_taken  out  1  head actual direction.
- upd_tg_pc  out  XLEN  head actual target.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  XLEN  correct next PC; valid while mispredict=1.

Behaviour:
- Reset (async, reset_n=0):
  - Pointers, count, mispredict and redirect_pc clear to 0; upd_* outputs are 0.
  - ex_ready=1.
- Push:
  - Occurs when ex_valid && ex_ready && (ex_cond || ex_uncond) && !flush.
  - ex_valid with neither ex_cond nor ex_uncond is ignored: no push, no pulse.
  - If ex_cond and ex_uncond are both 1, the instruction is treated as uncond.
- Actual outcome and next PC:
  - act_taken = ex_uncond | ex_taken.
  - act_npc = act_taken ? ex_tg_pc : ex_pc + 4, computed modulo 2^XLEN.
- Mispredict and redirect:
  - A mismatch exists when (act_taken != ex_pred_taken) or (act_npc != ex_pred_pc).
  - On a push with a mismatch, mispredict=1 and redirect_pc=act_npc are registered, so the pulse appears the cycle after acceptance.
  - Otherwise mispredict is 0 the next cycle; redirect_pc holds its last value.
- Head outputs:
  - upd_valid = (count != 0); upd_* are combinational from the head entry.
  - When empty, upd_cond, upd_taken, upd_pc and upd_tg_pc read as 0.
- Pop: occurs when upd_valid && !upd_stall; the head pointer advances.
- Latency: an entry pushed into an empty queue appears at upd_* the next cycle; there is no bypass.
- Full:
  - ex_ready=0 while count==DEPTH. ex_ready does not depend on a same-cycle pop.
  - The upstream stage holds ex_* stable while ex_ready=0.
- Simultaneous push and pop: both take effect and count is unchanged.
- Pointers: each is log2(DEPTH) bits and wraps naturally. count is log2(DEPTH)+1 bits.
- flush:
  - The next edge clears pointers and count.
  - A push in the same cycle is dropped.
  - mispredict is forced to 0 on the next cycle.
  - A pop in the same cycle is irrelevant.
- Reset mid-operation: the queue and any pending pulse are lost immediately (async).

Optional Feature:
- Macro: BP_RESOLVE_STATS_EN.
- Defined:
  - Adds 32-bit outputs stat_branches and stat_mispredicts.
  - stat_branches increments on every push; stat_mispredicts increments on every push that raises mispredict.
  - Both saturate at 0xFFFFFFFF, clear on reset, and are unaffected by flush.
- Undefined: the outputs and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push cond pc=0x100, taken=1, tg=0x200, pred_taken=1, pred_pc=0x200 -> the next cycle shows upd_valid=1, upd_cond=1, upd_pc=0x100, upd_tg_pc=0x200, and mispredict=0.
- Push cond pc=0x40, taken=0, pred_taken=1, pred_pc=0x80 -> the next cycle shows mispredict=1 for exactly one cycle with redirect_pc=0x44.
- Push jal pc=0x10, tg=0x300, ex_taken=0, pred_pc=0x14 -> upd_taken=1 and upd_cond=0; mispredict=1 with redirect_pc=0x300.
- Hold upd_stall=1 and push DEPTH=4 branches -> ex_ready=0 after the 4th push. Release the stall -> entries drain in order at one per cycle and ex_ready returns to 1 the cycle after the first pop.
- With 3 entries queued, assert flush together with a mismatching push -> the next cycle shows upd_valid=0, count=0 and mispredict=0.
- Push 0xFFFFFFFC not-taken with pred_pc=0x0 (XLEN=32) -> the pc+4 wrap gives 0 and mispredict=0. Also: ex_valid with a non-branch -> no entry and no pulse.

Source files
------------

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: branch resolve, mispredict redirect and predictor-update FIFO (stats counters via BP_RESOLVE_STATS_EN)
`ifndef XLEN
`define XLEN 32
`endif
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = `XLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_cond,
    input  logic            ex_uncond,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_tg_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_pc,
    output logic            upd_valid,
    input  logic            upd_stall,
    output logic            upd_cond,
    output logic [XLEN-1:0] upd_pc,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_tg_pc,
`ifdef BP_RESOLVE_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
`endif
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic            cond;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tg;
    } ent_t;

    ent_t            mem_q [DEPTH];
    ent_t            mem_d [DEPTH];
    ent_t            head;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            mp_q, mp_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            act_taken, mismatch, push, pop;
    logic [XLEN-1:0] act_npc;

    always_comb begin
        act_taken = ex_uncond | ex_taken;
        act_npc   = act_taken ? ex_tg_pc : ex_pc + XLEN'(4);
        mismatch  = (act_taken != ex_pred_taken) || (act_npc != ex_pred_pc);
        ex_ready  = cnt_q < (AW+1)'(DEPTH);
        upd_valid = cnt_q != '0;
        push      = ex_valid & ex_ready & (ex_cond | ex_uncond) & ~flush;
        pop       = upd_valid & ~upd_stall;
        head      = mem_q[rd_q];
        upd_cond  = upd_valid & head.cond;
        upd_taken = upd_valid & head.taken;
        upd_pc    = upd_valid ? head.pc : '0;
        upd_tg_pc = upd_valid ? head.tg : '0;
        mispredict  = mp_q;
        redirect_pc = rpc_q;
    end

    // A flush squashes the queue and suppresses any push; redirect_pc keeps its last value.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        mp_d  = push & mismatch;
        rpc_d = (push & mismatch) ? act_npc : rpc_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = '{cond: ex_cond & ~ex_uncond, taken: act_taken, pc: ex_pc, tg: ex_tg_pc};
                wr_d = wr_q + AW'(1);
            end
            if (pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            mp_q  <= 1'b0;
            rpc_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            mp_q  <= mp_d;
            rpc_q <= rpc_d;
        end
    end

    always_ff @(posedge clock) mem_q <= mem_d;

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] sb_q, sb_d, sm_q, sm_d;

    always_comb begin
        sb_d = (push && sb_q != '1) ? sb_q + 32'd1 : sb_q;
        sm_d = (push && mismatch && sm_q != '1) ? sm_q + 32'd1 : sm_q;
        stat_branches    = sb_q;
        stat_mispredicts = sm_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb_q <= '0;
            sm_q <= '0;
        end else begin
            sb_q <= sb_d;
            sm_q <= sm_d;
        end
    end
`endif
endmodule
